// File: rtl/copperv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : copperv_fetch (plus copperv_fetch_pkg)
// Purpose  : Instruction fetch stage of the copperv core. Issues sequential
//            read requests to instruction memory, keeps returned words and
//            their PCs in a small in-order queue, and hands them to decode
//            over a valid/ready handshake. A redirect flushes the queue and
//            restarts fetching at the new PC. Responses that were already in
//            flight at the time of the redirect are discarded on arrival.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            mem_cmd  (out)       - read request {addr, en, we=0, wr_data=0}
//            mem_rsp  (in)        - {ready pulse, rd_data}, one per request,
//                                   returned in order
//            redirect_valid/_pc   - flush and restart fetch at redirect_pc
//            instr_valid/_ready   - handshake to decode
//            instr_data/_pc       - head-of-queue word and its address
// Revision : 1.0 - initial release
// ============================================================================

package copperv_fetch_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        en;
        logic        we;
        logic [31:0] wr_data;
    } mem_cmd_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rd_data;
    } mem_rsp_t;

endpackage

module copperv_fetch
    import copperv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output mem_cmd_t    mem_cmd,
    input  mem_rsp_t    mem_rsp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    // Counter width holds 0..DEPTH; the occupancy sum needs one extra bit.
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);
    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_sum_w = c_cnt_w + 1;

    localparam logic [c_sum_w-1:0] c_depth    = c_sum_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_rsp_pc;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_cnt_w-1:0] r_discard;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [31:0]        r_q_pc   [DEPTH];
    logic [31:0]        r_q_data [DEPTH];

    // ------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------
    logic               w_rsp;
    logic               w_drop;
    logic               w_push;
    logic               w_valid;
    logic               w_pop;
    logic               w_issue;
    logic [c_sum_w-1:0] w_used;
    logic [31:0]        w_redirect_pc;

    function automatic logic [c_ptr_w-1:0] f_ptr_next(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    // A ready pulse with nothing outstanding is a protocol error and is ignored.
    assign w_rsp  = mem_rsp.ready && (r_inflight != '0);
    assign w_drop = w_rsp && (r_discard != '0);
    assign w_push = w_rsp && !redirect_valid && (r_discard == '0);

    assign w_valid = !rst && !redirect_valid && (r_count != '0);
    assign w_pop   = w_valid && instr_ready;

    // Slots already committed (outstanding requests plus buffered words).
    // A pop in the same cycle frees a slot immediately, which is what lets
    // DEPTH=2 with single-cycle memory stream one word per cycle.
    assign w_used  = {1'b0, r_inflight} + {1'b0, r_count} - c_sum_w'(w_pop);
    assign w_issue = !rst && !redirect_valid && (w_used < c_depth);

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_cmd      = '0;
        mem_cmd.en   = w_issue;
        mem_cmd.addr = r_fetch_pc;
    end

    assign instr_valid = w_valid;
    assign instr_data  = r_q_data[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle is stale; a
            // response arriving right now is dropped directly.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_inflight <= r_inflight - c_cnt_w'(w_rsp);
            r_discard  <= r_inflight - c_cnt_w'(w_rsp);
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
            r_inflight <= r_inflight + c_cnt_w'(w_issue) - c_cnt_w'(w_rsp);
            r_discard  <= r_discard - c_cnt_w'(w_drop);
            r_count    <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Queue storage needs no reset: r_count gates its visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
            r_q_data[r_wr_ptr] <= mem_rsp.rd_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rsp.ready && (r_inflight == '0)))
                else $error("copperv_fetch: mem_rsp.ready with no request outstanding");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_copperv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_copperv_fetch
// Purpose  : Directed self-checking bench for copperv_fetch. One instance uses
//            the default RESET_PC with a memory model of selectable latency;
//            a second instance uses RESET_PC = 32'hFFFF_FFF8 to cover PC wrap.
//            Memory returns rd_data = addr ^ 32'hA5A5_A5A5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_copperv_fetch;
    import copperv_fetch_pkg::*;

    localparam logic [31:0] c_pat = 32'hA5A5_A5A5;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    mem_cmd_t    mem_cmd, mem_cmd2;
    mem_rsp_t    mem_rsp, mem_rsp2;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        instr_ready    = 1'b1;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr_data, instr_data2, instr_pc, instr_pc2;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;

    copperv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .mem_cmd(mem_cmd), .mem_rsp(mem_rsp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    copperv_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst2), .mem_cmd(mem_cmd2), .mem_rsp(mem_rsp2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .instr_data(instr_data2), .instr_pc(instr_pc2)
    );

    // Memory for u_dut: fixed-latency pipeline, latency 1..4, reset with the DUT.
    logic        pipe_v [0:3];
    logic [31:0] pipe_a [0:3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= 32'h0;
            end
        end else begin
            pipe_v[0] <= mem_cmd.en;
            pipe_a[0] <= mem_cmd.addr;
            for (int i = 1; i < 4; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end
    always_comb begin
        mem_rsp.ready   = pipe_v[mem_lat-1];
        mem_rsp.rd_data = pipe_a[mem_lat-1] ^ c_pat;
    end

    // Memory for u_dut_wrap: single-cycle latency.
    logic        m2_v;
    logic [31:0] m2_a;
    always @(posedge clk) begin
        if (rst2) begin
            m2_v <= 1'b0;
            m2_a <= 32'h0;
        end else begin
            m2_v <= mem_cmd2.en;
            m2_a <= mem_cmd2.addr;
        end
    end
    always_comb begin
        mem_rsp2.ready   = m2_v;
        mem_rsp2.rd_data = m2_a ^ c_pat;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Holds reset for a few cycles, then releases it at a negedge. On return
    // the caller is in the first cycle with rst low.
    task automatic do_reset(input int lat);
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        mem_lat        = lat;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance one cycle and settle combinational outputs.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          issued;
        logic [31:0] iss_addr [0:1];
        bit          found;

        // ---------------- Reset values ----------------
        next_cycle();
        next_cycle();
        check_eq("rst_en",       32'(mem_cmd.en),      32'd0);
        check_eq("rst_we",       32'(mem_cmd.we),      32'd0);
        check_eq("rst_wr_data",  mem_cmd.wr_data,      32'd0);
        check_eq("rst_valid",    32'(instr_valid),     32'd0);
        check_eq("rst2_en",      32'(mem_cmd2.en),     32'd0);
        check_eq("rst2_valid",   32'(instr_valid2),    32'd0);

        // ---------------- Streaming, 1-cycle memory ----------------
        instr_ready = 1'b1;
        do_reset(1);
        #1;
        check_eq("s_first_en",   32'(mem_cmd.en),      32'd1);
        check_eq("s_first_addr", mem_cmd.addr,         32'h0);
        next_cycle();
        check_eq("s_valid_r1",   32'(instr_valid),     32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check_eq("s_valid",  32'(instr_valid),     32'd1);
            check_eq("s_pc",     instr_pc,             32'(4 * k));
            check_eq("s_data",   instr_data,           32'(4 * k) ^ c_pat);
        end

        // ---------------- Backpressure ----------------
        instr_ready = 1'b0;
        do_reset(1);
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (mem_cmd.en) begin
                if (issued < 2) iss_addr[issued] = mem_cmd.addr;
                issued++;
            end
        end
        check_eq("bp_issued",    32'(issued),          32'd2);
        check_eq("bp_addr0",     iss_addr[0],          32'h0);
        check_eq("bp_addr1",     iss_addr[1],          32'h4);
        check_eq("bp_en_low",    32'(mem_cmd.en),      32'd0);
        check_eq("bp_valid",     32'(instr_valid),     32'd1);
        check_eq("bp_hold_pc",   instr_pc,             32'h0);
        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next_cycle();
            check_eq("bp_rel_valid", 32'(instr_valid), 32'd1);
            check_eq("bp_rel_pc",    instr_pc,         32'(4 * k));
            check_eq("bp_rel_data",  instr_data,       32'(4 * k) ^ c_pat);
        end

        // ---------------- Redirect with 2 in flight, 3-cycle memory ----------------
        instr_ready = 1'b1;
        do_reset(3);
        #1;
        next_cycle();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check_eq("rd_en_in_redirect",    32'(mem_cmd.en),  32'd0);
        check_eq("rd_valid_in_redirect", 32'(instr_valid), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            if (mem_cmd.en) begin
                found = 1'b1;
                check_eq("rd_first_addr", mem_cmd.addr, 32'h0000_0100);
            end
        end
        check_eq("rd_en_seen", 32'(found), 32'd1);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            next_cycle();
            if (instr_valid) begin
                found = 1'b1;
                check_eq("rd_first_pc",   instr_pc,   32'h0000_0100);
                check_eq("rd_first_data", instr_data, 32'h0000_0100 ^ c_pat);
            end
        end
        check_eq("rd_valid_seen", 32'(found), 32'd1);
        next_cycle();
        check_eq("rd_second_valid", 32'(instr_valid), 32'd1);
        check_eq("rd_second_pc",    instr_pc,         32'h0000_0104);

        // ---------------- Redirect + response + pending pop ----------------
        instr_ready = 1'b1;
        do_reset(1);
        #1;
        next_cycle();
        next_cycle();
        next_cycle();
        check_eq("rc_pre_pc", instr_pc, 32'h4);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check_eq("rc_valid_in_redirect", 32'(instr_valid), 32'd0);
        check_eq("rc_en_in_redirect",    32'(mem_cmd.en),  32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check_eq("rc_empty_next",  32'(instr_valid), 32'd0);
        check_eq("rc_restart_en",  32'(mem_cmd.en),  32'd1);
        check_eq("rc_restart_adr", mem_cmd.addr,     32'h0000_0200);
        next_cycle();
        check_eq("rc_valid_r1",    32'(instr_valid), 32'd0);
        next_cycle();
        check_eq("rc_valid_r2",    32'(instr_valid), 32'd1);
        check_eq("rc_pc",          instr_pc,         32'h0000_0200);
        check_eq("rc_data",        instr_data,       32'h0000_0200 ^ c_pat);

        // ---------------- Reset mid-stream with queue full ----------------
        instr_ready = 1'b0;
        do_reset(1);
        repeat (6) next_cycle();
        check_eq("mr_full_valid", 32'(instr_valid), 32'd1);
        check_eq("mr_full_en",    32'(mem_cmd.en),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        next_cycle();
        check_eq("mr_valid_after", 32'(instr_valid), 32'd0);
        check_eq("mr_en_after",    32'(mem_cmd.en),  32'd0);
        @(negedge clk);
        rst         = 1'b0;
        instr_ready = 1'b1;
        #1;
        check_eq("mr_restart_en",   32'(mem_cmd.en), 32'd1);
        check_eq("mr_restart_addr", mem_cmd.addr,    32'h0);
        next_cycle();
        next_cycle();
        check_eq("mr_first_valid", 32'(instr_valid), 32'd1);
        check_eq("mr_first_pc",    instr_pc,         32'h0);

        // ---------------- PC wrap from RESET_PC = FFFF_FFF8 ----------------
        @(negedge clk);
        rst  = 1'b1;
        rst2 = 1'b0;
        #1;
        check_eq("wr_first_en",   32'(mem_cmd2.en), 32'd1);
        check_eq("wr_first_addr", mem_cmd2.addr,    32'hFFFF_FFF8);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check_eq("wr_valid", 32'(instr_valid2), 32'd1);
            check_eq("wr_pc",    instr_pc2,         32'hFFFF_FFF8 + 32'(4 * k));
            check_eq("wr_data",  instr_data2,       (32'hFFFF_FFF8 + 32'(4 * k)) ^ c_pat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
